// File: rtl/decode_seq.sv
// Registered multi-cycle instruction decoder: sequenced MUL, flag-conditional branches with flush.
// Optional illegal-opcode trap (HALT state, sticky illegal flag) enabled by DECODE_ILLEGAL_TRAP_EN.
module decode_seq #(
    parameter int A_SIZE     = 3,
    parameter int O_SIZE     = 6,
    parameter int FLAG_W     = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [O_SIZE-1:0] opCode,
    input  logic              instrValid,
    input  logic [FLAG_W-1:0] aluFlags,
    output logic [A_SIZE-1:0] aluFunc,
    output logic              aluImmediate,
    output logic              pcInc,
    output logic              pcBranchAbs,
    output logic              pcBranchRel,
    output logic              writeReg,
    output logic              busy,
    output logic              illegal
);
    localparam logic [O_SIZE-1:0] OP_NOP  = O_SIZE'(0);
    localparam logic [O_SIZE-1:0] OP_LDI  = O_SIZE'(1);
    localparam logic [O_SIZE-1:0] OP_ADD  = O_SIZE'(2);
    localparam logic [O_SIZE-1:0] OP_ADDI = O_SIZE'(3);
    localparam logic [O_SIZE-1:0] OP_MUL  = O_SIZE'(4);
    localparam logic [O_SIZE-1:0] OP_JMP  = O_SIZE'(5);
    localparam logic [O_SIZE-1:0] OP_BRZ  = O_SIZE'(6);
    localparam logic [O_SIZE-1:0] OP_BRNZ = O_SIZE'(7);

    localparam logic [A_SIZE-1:0] ALU_A   = A_SIZE'(0);
    localparam logic [A_SIZE-1:0] ALU_B   = A_SIZE'(1);
    localparam logic [A_SIZE-1:0] ALU_ADD = A_SIZE'(2);
    localparam logic [A_SIZE-1:0] ALU_MUL = A_SIZE'(3);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

`ifdef DECODE_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH, HALT} state_t;
`else
    typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH} state_t;
`endif

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic [A_SIZE-1:0] func_next;
    logic              imm_next, inc_next, abs_next, rel_next, wr_next, busy_next;
    logic              taken;
    logic              unused_flags;

    // Only the Z flag steers branches; the remaining flag bits are carried for future conditions.
    assign taken        = (opCode == OP_BRZ) ? aluFlags[0] : ~aluFlags[0];
    assign unused_flags = ^aluFlags[FLAG_W-1:1];

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_next;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        func_next  = ALU_A;
        imm_next   = 1'b0;
        inc_next   = 1'b0;
        abs_next   = 1'b0;
        rel_next   = 1'b0;
        wr_next    = 1'b0;
        busy_next  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_next = illegal;
`endif
        case (state)
            RUN: begin
                if (instrValid) begin
                    case (opCode)
                        OP_NOP: inc_next = 1'b1;
                        OP_LDI: begin
                            func_next = ALU_B;
                            imm_next  = 1'b1;
                            wr_next   = 1'b1;
                            inc_next  = 1'b1;
                        end
                        OP_ADD, OP_ADDI: begin
                            func_next = ALU_ADD;
                            imm_next  = (opCode == OP_ADDI);
                            wr_next   = 1'b1;
                            inc_next  = 1'b1;
                        end
                        OP_MUL: begin
                            func_next = ALU_MUL;
                            if (MUL_CYCLES == 1) begin
                                wr_next  = 1'b1;
                                inc_next = 1'b1;
                            end else begin
                                busy_next  = 1'b1;
                                cnt_next   = MUL_LOAD;
                                state_next = MUL_WAIT;
                            end
                        end
                        OP_JMP: begin
                            abs_next   = 1'b1;
                            busy_next  = 1'b1;
                            state_next = FLUSH;
                        end
                        OP_BRZ, OP_BRNZ: begin
                            if (taken) begin
                                rel_next   = 1'b1;
                                busy_next  = 1'b1;
                                state_next = FLUSH;
                            end else begin
                                inc_next = 1'b1;
                            end
                        end
                        default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                            illegal_next = 1'b1;
                            busy_next    = 1'b1;
                            state_next   = HALT;
`else
                            inc_next = 1'b1;
`endif
                        end
                    endcase
                end
            end
            MUL_WAIT: begin
                func_next = ALU_MUL;
                if (cnt <= 4'd1) begin
                    wr_next    = 1'b1;
                    inc_next   = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = RUN;
                end else begin
                    busy_next = 1'b1;
                    cnt_next  = cnt - 4'd1;
                end
            end
            // Bubble that drops the instruction fetched behind the branch.
            FLUSH: state_next = RUN;
`ifdef DECODE_ILLEGAL_TRAP_EN
            HALT: busy_next = 1'b1;
`endif
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 4'd0;
            aluFunc      <= ALU_A;
            aluImmediate <= 1'b0;
            pcInc        <= 1'b0;
            pcBranchAbs  <= 1'b0;
            pcBranchRel  <= 1'b0;
            writeReg     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            aluFunc      <= func_next;
            aluImmediate <= imm_next;
            pcInc        <= inc_next;
            pcBranchAbs  <= abs_next;
            pcBranchRel  <= rel_next;
            writeReg     <= wr_next;
            busy         <= busy_next;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) illegal <= 1'b0;
        else       illegal <= illegal_next;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: single-cycle opcode table plus hand-written MUL, branch, reset and trap sequences.
module tb_decode_seq;
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_LDI  = 6'd1;
    localparam logic [5:0] OP_ADD  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_MUL  = 6'd4;
    localparam logic [5:0] OP_JMP  = 6'd5;
    localparam logic [5:0] OP_BRZ  = 6'd6;
    localparam logic [5:0] OP_BRNZ = 6'd7;
    localparam logic [5:0] OP_BAD  = 6'h3F;

    localparam logic [2:0] ALU_A   = 3'd0;
    localparam logic [2:0] ALU_B   = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_MUL = 3'd3;

    typedef struct packed {
        logic [2:0] func;
        logic       imm, inc, abs, rel, wr, busy, ill;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [5:0] op;
        logic [3:0] flags;
        outs_t      exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opCode = OP_NOP;
    logic       instrValid = 1'b0;
    logic [3:0] aluFlags = 4'h0;
    logic [2:0] aluFunc;
    logic       aluImmediate, pcInc, pcBranchAbs, pcBranchRel, writeReg, busy, illegal;

    int    errors = 0;
    int    checks = 0;
    outs_t sb_q[$];
    string name_q[$];
    vec_t  table_v[9];

    always #5 clk = ~clk;

    decode_seq #(.A_SIZE(3), .O_SIZE(6), .FLAG_W(4), .MUL_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .instrValid(instrValid), .aluFlags(aluFlags),
        .aluFunc(aluFunc), .aluImmediate(aluImmediate), .pcInc(pcInc), .pcBranchAbs(pcBranchAbs),
        .pcBranchRel(pcBranchRel), .writeReg(writeReg), .busy(busy), .illegal(illegal)
    );

    function automatic outs_t mk(input logic [2:0] f, input logic imm, input logic inc, input logic abs,
                                 input logic rel, input logic wr, input logic bsy, input logic ill);
        outs_t o;
        o.func = f; o.imm = imm; o.inc = inc; o.abs = abs; o.rel = rel; o.wr = wr; o.busy = bsy; o.ill = ill;
        return o;
    endfunction

    // Drive one cycle of inputs, queue its expected outputs, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [5:0] op, input logic [3:0] fl,
                        input outs_t exp, input string nm);
        outs_t act, want;
        string wname;
        reset = r; instrValid = v; opCode = op; aluFlags = fl;
        sb_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        act  = {aluFunc, aluImmediate, pcInc, pcBranchAbs, pcBranchRel, writeReg, busy, illegal};
        want = sb_q.pop_front();
        wname = name_q.pop_front();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got func=%0d imm=%b inc=%b abs=%b rel=%b wr=%b busy=%b ill=%b, want func=%0d imm=%b inc=%b abs=%b rel=%b wr=%b busy=%b ill=%b",
                     wname, act.func, act.imm, act.inc, act.abs, act.rel, act.wr, act.busy, act.ill,
                     want.func, want.imm, want.inc, want.abs, want.rel, want.wr, want.busy, want.ill);
        end
        checks++;
        if (!$onehot0({pcInc, pcBranchAbs, pcBranchRel})) begin
            errors++;
            $display("FAIL %s_pc_onehot: got inc/abs/rel=%b%b%b, want at most one set", wname, pcInc, pcBranchAbs, pcBranchRel);
        end
    endtask

    outs_t RST, INC, LDI_O, ADD_O, ADDI_O, MULB, MULD, REL, ABS;

    initial begin
        RST    = mk(ALU_A,   0, 0, 0, 0, 0, 0, 0);
        INC    = mk(ALU_A,   0, 1, 0, 0, 0, 0, 0);
        LDI_O  = mk(ALU_B,   1, 1, 0, 0, 1, 0, 0);
        ADD_O  = mk(ALU_ADD, 0, 1, 0, 0, 1, 0, 0);
        ADDI_O = mk(ALU_ADD, 1, 1, 0, 0, 1, 0, 0);
        MULB   = mk(ALU_MUL, 0, 0, 0, 0, 0, 1, 0);
        MULD   = mk(ALU_MUL, 0, 1, 0, 0, 1, 0, 0);
        REL    = mk(ALU_A,   0, 0, 0, 1, 0, 1, 0);
        ABS    = mk(ALU_A,   0, 0, 1, 0, 0, 1, 0);

        table_v[0] = '{1'b1, 1'b1, OP_LDI,  4'h0, RST,    "reset_c1"};
        table_v[1] = '{1'b1, 1'b1, OP_ADD,  4'h0, RST,    "reset_c2"};
        table_v[2] = '{1'b0, 1'b1, OP_LDI,  4'h0, LDI_O,  "ldi"};
        table_v[3] = '{1'b0, 1'b1, OP_NOP,  4'h0, INC,    "nop"};
        table_v[4] = '{1'b0, 1'b1, OP_ADD,  4'h0, ADD_O,  "add"};
        table_v[5] = '{1'b0, 1'b1, OP_ADDI, 4'h0, ADDI_O, "addi"};
        table_v[6] = '{1'b0, 1'b0, OP_ADD,  4'h0, RST,    "invalid_bubble"};
        table_v[7] = '{1'b0, 1'b1, OP_BRZ,  4'hE, INC,    "brz_not_taken_hi_flags"};
        table_v[8] = '{1'b0, 1'b1, OP_BRNZ, 4'h1, INC,    "brnz_not_taken"};

        for (int i = 0; i < 9; i++)
            step(table_v[i].rst, table_v[i].valid, table_v[i].op, table_v[i].flags, table_v[i].exp, table_v[i].name);

        // MUL held for three cycles, following ADD only accepted afterwards.
        step(0, 1, OP_MUL, 4'h0, MULB,  "mul_c1");
        step(0, 1, OP_ADD, 4'h0, MULB,  "mul_c2");
        step(0, 1, OP_ADD, 4'h0, MULD,  "mul_c3");
        step(0, 1, OP_ADD, 4'h0, ADD_O, "mul_then_add");

        // Taken / not-taken conditional branches.
        step(0, 1, OP_BRZ,  4'h1, REL,   "brz_taken");
        step(0, 1, OP_ADD,  4'h0, RST,   "brz_flush");
        step(0, 1, OP_ADD,  4'h0, ADD_O, "after_flush");
        step(0, 1, OP_BRZ,  4'h0, INC,   "brz_not_taken");
        step(0, 1, OP_BRNZ, 4'hE, REL,   "brnz_taken");
        step(0, 1, OP_LDI,  4'h0, RST,   "brnz_flush");

        // JMP followed by idle cycles.
        step(0, 1, OP_JMP, 4'h0, ABS, "jmp");
        step(0, 0, OP_ADD, 4'h0, RST, "jmp_flush");
        step(0, 0, OP_ADD, 4'h0, RST, "idle_1");
        step(0, 0, OP_ADD, 4'h0, RST, "idle_2");

        // Reset during the second MUL cycle, then a full MUL again.
        step(0, 1, OP_MUL, 4'h0, MULB,  "mul2_c1");
        step(0, 1, OP_MUL, 4'h0, MULB,  "mul2_c2");
        step(1, 1, OP_MUL, 4'h0, RST,   "mul_reset");
        step(0, 1, OP_MUL, 4'h0, MULB,  "mul3_c1");
        step(0, 1, OP_ADD, 4'h0, MULB,  "mul3_c2");
        step(0, 1, OP_ADD, 4'h0, MULD,  "mul3_c3");
        step(0, 1, OP_ADD, 4'h0, ADD_O, "mul3_then_add");

        // Unknown opcode.
`ifdef DECODE_ILLEGAL_TRAP_EN
        step(0, 1, OP_BAD, 4'h0, mk(ALU_A, 0, 0, 0, 0, 0, 1, 1), "illegal_trap");
        for (int k = 0; k < 10; k++)
            step(0, 1, OP_ADD, 4'h0, mk(ALU_A, 0, 0, 0, 0, 0, 1, 1), "halt_hold");
        step(1, 1, OP_ADD, 4'h0, RST,   "halt_reset");
        step(0, 1, OP_LDI, 4'h0, LDI_O, "after_halt_ldi");
`else
        step(0, 1, OP_BAD, 4'h0, INC,   "unknown_as_nop");
        step(0, 1, OP_ADD, 4'h0, ADD_O, "after_unknown");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
